dot_acc_stage: RTL and testbench



---
 rtl/dot_acc_stage.sv | 150 +++++++++++++++
 tb/tb_dot_acc_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_acc_stage.sv
// Vector dot-product accumulate stage: sums len unsigned products into an ACC_W-bit result.
// Optional macro DOT_ACC_SAT_EN: clamp the accumulator to all-ones on overflow instead of wrapping.
module dot_acc_stage #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res,
    output logic              ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               prod_ready_q, prod_ready_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;

    logic [ACC_W:0]     sum_s;
    logic               carry_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               last_s;
    logic               xfer_s;

    // Adder, overflow handling and end-of-vector detection
    always_comb begin
        sum_s   = {1'b0, acc_q} + (ACC_W + 1)'(prod);
        carry_s = sum_s[ACC_W];
`ifdef DOT_ACC_SAT_EN
        // Once clamped, the accumulator stays pinned for the rest of the vector.
        if (carry_s || ovf_q) begin
            acc_next_s = {ACC_W{1'b1}};
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
`else
        acc_next_s = sum_s[ACC_W-1:0];
`endif
        // Compare one bit wider so a max-length vector cannot alias through a wrap.
        last_s = (({1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_q});
        xfer_s = prod_valid & prod_ready_q;
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = len;
                    cnt_d = {LEN_W{1'b0}};
                    acc_d = {ACC_W{1'b0}};
                    ovf_d = 1'b0;
                    if (len == {LEN_W{1'b0}}) begin
                        res_d   = {ACC_W{1'b0}};
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                if (xfer_s) begin
                    acc_d = acc_next_s;
                    cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    ovf_d = ovf_q | carry_s;
                    if (last_s) begin
                        res_d   = acc_next_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        prod_ready_d = (state_d == S_ACC);
        res_valid_d  = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= {LEN_W{1'b0}};
            cnt_q        <= {LEN_W{1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            res_q        <= {ACC_W{1'b0}};
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign res_valid  = res_valid_q;
    assign res        = res_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dot_acc_stage.sv
// Directed bench for dot_acc_stage: a 24-bit and a 20-bit accumulator instance driven in lock-step.
module tb_dot_acc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [15:0] prod;
    logic        res_ready;

    logic        prod_ready, res_valid, ovf, busy;
    logic [23:0] res;
    logic        prod_ready20, res_valid20, ovf20, busy20;
    logic [19:0] res20;

    int total = 0;
    int bad   = 0;

    dot_acc_stage #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
        .res_valid(res_valid), .res_ready(res_ready), .res(res),
        .ovf(ovf), .busy(busy)
    );

    dot_acc_stage #(.PROD_W(16), .ACC_W(20), .LEN_W(8)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready20), .prod(prod),
        .res_valid(res_valid20), .res_ready(res_ready), .res(res20),
        .ovf(ovf20), .busy(busy20)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one product after gap idle cycles and hold it until accepted.
    task automatic push(input logic [15:0] v, input int gap);
        int n;
        prod_valid = 1'b0;
        repeat (gap) tick();
        prod_valid = 1'b1;
        prod       = v;
        n = 0;
        while (!prod_ready && n < 20) begin
            tick();
            n++;
        end
        if (!prod_ready) begin
            total++; bad++;
            $display("FAIL push_timeout got prod_ready=%0b exp=1", prod_ready);
        end
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = 8'd0; prod_valid = 1'b0;
        prod = 16'd0; res_ready = 1'b0;
        repeat (3) tick();
        total++;
        if ({prod_ready, res_valid, busy, ovf} !== 4'b0000 || res !== 24'd0) begin
            bad++;
            $display("FAIL reset_outputs got pr=%0b rv=%0b busy=%0b ovf=%0b res=%0d exp all 0",
                     prod_ready, res_valid, busy, ovf, res);
        end
        total++;
        if ({prod_ready20, res_valid20, busy20, ovf20} !== 4'b0000 || res20 !== 20'd0) begin
            bad++;
            $display("FAIL reset_outputs20 got pr=%0b rv=%0b busy=%0b ovf=%0b res=%0d exp all 0",
                     prod_ready20, res_valid20, busy20, ovf20, res20);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        total++;
        if ({busy, prod_ready, res_valid} !== 3'b110) begin
            bad++;
            $display("FAIL basic_enter_acc got busy=%0b pr=%0b rv=%0b exp 1 1 0", busy, prod_ready, res_valid);
        end
        push(16'd3, 0); push(16'd5, 0); push(16'd7, 0);
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_early_valid got rv=%0b busy=%0b exp 0 1", res_valid, busy);
        end
        push(16'd9, 0);
        total++;
        if (res_valid !== 1'b1 || res !== 24'd24 || ovf !== 1'b0 || busy !== 1'b1 || prod_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_result got rv=%0b res=%0d ovf=%0b busy=%0b pr=%0b exp 1 24 0 1 0",
                     res_valid, res, ovf, busy, prod_ready);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res !== 24'd24) begin
            bad++;
            $display("FAIL basic_handshake got rv=%0b busy=%0b res=%0d exp 0 0 24", res_valid, busy, res);
        end
    endtask

    task automatic test_zero_len();
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res !== 24'd0 || ovf !== 1'b0 || prod_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_len got rv=%0b res=%0d ovf=%0b pr=%0b busy=%0b exp 1 0 0 0 1",
                     res_valid, res, ovf, prod_ready, busy);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || prod_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_done got rv=%0b pr=%0b busy=%0b exp 0 0 0", res_valid, prod_ready, busy);
        end
    endtask

    task automatic test_bubbles();
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        push(16'd65025, 0); push(16'd65025, 2); push(16'd65025, 2);
        total++;
        if (res_valid !== 1'b1 || res !== 24'd195075 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL bubbles_result got rv=%0b res=%0d ovf=%0b exp 1 195075 0", res_valid, res, ovf);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res !== 24'd195075 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold cyc=%0d got rv=%0b res=%0d exp 1 195075", i, res_valid, res);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release got rv=%0b busy=%0b exp 0 0", res_valid, busy);
        end
    endtask

    task automatic test_overflow();
        logic [19:0] exp20;
`ifdef DOT_ACC_SAT_EN
        exp20 = 20'hFFFFF;
`else
        exp20 = 20'hD02FF;
`endif
        start = 1'b1; len = 8'd255;
        tick();
        start = 1'b0;
        for (int i = 0; i < 255; i++) push(16'd65025, 0);
        total++;
        if (res_valid !== 1'b1 || res !== 24'hFD02FF || ovf !== 1'b0) begin
            bad++;
            $display("FAIL max_len_24 got rv=%0b res=%h ovf=%0b exp 1 fd02ff 0", res_valid, res, ovf);
        end
        total++;
        if (res_valid20 !== 1'b1 || res20 !== exp20 || ovf20 !== 1'b1) begin
            bad++;
            $display("FAIL overflow_20 got rv=%0b res=%h ovf=%0b exp 1 %h 1", res_valid20, res20, ovf20, exp20);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) push(16'd1000, 0);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({prod_ready, res_valid, busy, ovf} !== 4'b0000 || res !== 24'd0 || ovf20 !== 1'b0 || res20 !== 20'd0) begin
            bad++;
            $display("FAIL reset_mid got pr=%0b rv=%0b busy=%0b ovf=%0b res=%0d ovf20=%0b res20=%0d exp all 0",
                     prod_ready, res_valid, busy, ovf, res, ovf20, res20);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        push(16'd1, 0); push(16'd2, 0);
        total++;
        if (res_valid !== 1'b1 || res !== 24'd3 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after got rv=%0b res=%0d ovf=%0b exp 1 3 0", res_valid, res, ovf);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_ignored_start();
        start = 1'b1; len = 8'd3;
        tick();
        len = 8'd7;
        push(16'd10, 0); push(16'd20, 0); push(16'd30, 0);
        total++;
        if (res_valid !== 1'b1 || res !== 24'd60) begin
            bad++;
            $display("FAIL ignore_start_acc got rv=%0b res=%0d exp 1 60", res_valid, res);
        end
        len = 8'd5; res_ready = 1'b1;
        tick();
        start = 1'b0; res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_done got rv=%0b busy=%0b exp 0 0", res_valid, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || prod_ready !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_idle got busy=%0b pr=%0b exp 0 0", busy, prod_ready);
        end
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        push(16'd4, 0); push(16'd6, 0);
        total++;
        if (res_valid !== 1'b1 || res !== 24'd10) begin
            bad++;
            $display("FAIL ignore_start_next got rv=%0b res=%0d exp 1 10", res_valid, res);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Zero-length vectors must never raise prod_ready at any sampled point.
    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_bubbles();
        test_overflow();
        test_reset_mid();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
